// File: rtl/au_neg_pipe.sv
// Purpose : pipelined conditional 2's complementer (pass / negate / abs / neg-abs) with overflow flag and optional saturation.
// Latency : STAGES cycles from the cycle a beat is presented to the cycle it appears on z; 1 beat/cycle sustained.
// Backpr. : valid/ready stream; empty slots collapse bubbles, and in_ready is combinational from out_ready.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  input handshake; a (WIDTH, 2's complement) and mode (2b) qualify with in_valid
//   out_valid / out_ready output handshake; z (WIDTH) result, ovf = result not representable
//   mode: 00 pass, 01 negate, 10 abs, 11 -|a|
module au_neg_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int SAT    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             ovf
);

  generate
    if (WIDTH < 1 || STAGES < 1 || STAGES > 4 || (SAT != 0 && SAT != 1)) begin : g_param_err
      $fatal(1, "au_neg_pipe: illegal parameters WIDTH=%0d STAGES=%0d SAT=%0d", WIDTH, STAGES, SAT);
    end
  endgenerate

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] MOST_NEG = ONE << (WIDTH - 1);
  localparam logic [WIDTH-1:0] MAX_POS  = ~MOST_NEG;

  // ---------------------------------------------------------------
  // Slot-0 arithmetic: a single inv+1 negator shared by all modes.
  // ---------------------------------------------------------------
  logic             msb;
  logic             neg_en;
  logic [WIDTH-1:0] a_neg;
  logic [WIDTH-1:0] r;
  logic             ovf_new;
  logic [WIDTH-1:0] z_new;

  always_comb begin
    msb    = a[WIDTH-1];
    neg_en = 1'b0;
    case (mode)
      2'b01:   neg_en = 1'b1;
      2'b10:   neg_en = msb;
      2'b11:   neg_en = ~msb;
      default: neg_en = 1'b0;
    endcase
    a_neg   = (~a) + ONE;
    r       = neg_en ? a_neg : a;
    // Only negating the most negative value leaves the range; -|M| = M is fine.
    ovf_new = neg_en & (a == MOST_NEG);
    z_new   = ((SAT != 0) && ovf_new) ? MAX_POS : r;
  end

  // ---------------------------------------------------------------
  // Slot pipeline
  // ---------------------------------------------------------------
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] ovf_q, ovf_d;
  logic [WIDTH-1:0]  z_q [STAGES];
  logic [WIDTH-1:0]  z_d [STAGES];
  logic [STAGES-1:0] ld;      // slot may take new content this cycle
  logic              chain;

  always_comb begin
    // A slot can load when it is empty or its current beat moves on.
    // Walking from the output back gives the bubble-collapsing ready chain.
    ld    = '0;
    chain = out_ready | ~v_q[STAGES-1];
    ld[STAGES-1] = chain;
    for (int k = STAGES - 2; k >= 0; k--) begin
      chain = ~v_q[k] | chain;
      ld[k] = chain;
    end

    v_d   = v_q;
    ovf_d = ovf_q;
    z_d   = z_q;

    if (ld[0]) begin
      v_d[0] = in_valid;
      if (in_valid) begin
        z_d[0]   = z_new;
        ovf_d[0] = ovf_new;
      end
    end

    for (int k = 1; k < STAGES; k++) begin
      if (ld[k]) begin
        v_d[k] = v_q[k-1];
        // Data only moves with a valid beat, so idle slots keep quiet.
        if (v_q[k-1]) begin
          z_d[k]   = z_q[k-1];
          ovf_d[k] = ovf_q[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      ovf_q <= '0;
      z_q   <= '{default: '0};
    end else begin
      v_q   <= v_d;
      ovf_q <= ovf_d;
      z_q   <= z_d;
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = v_q[STAGES-1];
  assign z         = z_q[STAGES-1];
  assign ovf       = ovf_q[STAGES-1];

endmodule

// File: tb/tb_au_neg_pipe.sv
module tb_au_neg_pipe;

  logic clk;
  logic rst_n;

  // Directed stimulus: WIDTH=8, STAGES=2 with SAT=0 (u0) and SAT=1 (u1) side by side.
  logic       in_valid, out_ready;
  logic [7:0] a;
  logic [1:0] mode;
  logic       in_ready0, out_valid0, ovf0;
  logic [7:0] z0;
  logic       in_ready1, out_valid1, ovf1;
  logic [7:0] z1;

  // Random stimulus: WIDTH=17/STAGES=4/SAT=0 (u2) and WIDTH=1/STAGES=1/SAT=1 (u3).
  logic        rv, rr;
  logic [16:0] ra;
  logic [1:0]  rm;
  logic        ir2, ov2, ovf2;
  logic [16:0] z2;
  logic        ir3, ov3, ovf3;
  logic [0:0]  z3;

  int checks = 0;
  int errors = 0;

  au_neg_pipe #(.WIDTH(8), .STAGES(2), .SAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .a(a), .mode(mode),
    .out_valid(out_valid0), .out_ready(out_ready), .z(z0), .ovf(ovf0));

  au_neg_pipe #(.WIDTH(8), .STAGES(2), .SAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .a(a), .mode(mode),
    .out_valid(out_valid1), .out_ready(out_ready), .z(z1), .ovf(ovf1));

  au_neg_pipe #(.WIDTH(17), .STAGES(4), .SAT(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(rv), .in_ready(ir2), .a(ra), .mode(rm),
    .out_valid(ov2), .out_ready(rr), .z(z2), .ovf(ovf2));

  au_neg_pipe #(.WIDTH(1), .STAGES(1), .SAT(1)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(rv), .in_ready(ir3), .a(ra[0:0]), .mode(rm),
    .out_valid(ov3), .out_ready(rr), .z(z3), .ovf(ovf3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are looked at on the falling edge.
  task automatic drive(input logic iv, input logic [7:0] av, input logic [1:0] m, input logic ordy);
    @(posedge clk);
    #1;
    in_valid  = iv;
    a         = av;
    mode      = m;
    out_ready = ordy;
    @(negedge clk);
  endtask

  // Reference: plain arithmetic negation, result packed as {ovf, z}.
  function automatic logic [31:0] ref_fn(input int w, input int sat, input logic [16:0] av, input logic [1:0] m);
    int unsigned mask, val, mn, r;
    logic neg, ov;
    mask = (32'd1 << w) - 32'd1;
    val  = 32'(av) & mask;
    mn   = 32'd1 << (w - 1);
    neg  = (m == 2'd1) || (m == 2'd2 && (val & mn) != 0) || (m == 2'd3 && (val & mn) == 0);
    ov   = neg && (val == mn);
    r    = neg ? ((32'd0 - val) & mask) : val;
    if (sat != 0 && ov) r = mn - 32'd1;
    return (32'(ov) << w) | r;
  endfunction

  // Scoreboards for the random instances.
  logic [31:0] q2[$];
  logic [31:0] q3[$];
  int n2 = 0;
  int n3 = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q2.delete();
      q3.delete();
    end else begin
      if (ov2 && rr) begin
        chk("rnd_w17_nonempty", 32'(q2.size() != 0), 32'd1);
        if (q2.size() != 0) chk("rnd_w17", 32'({ovf2, z2}), q2.pop_front());
        n2++;
      end
      if (ov3 && rr) begin
        chk("rnd_w1_nonempty", 32'(q3.size() != 0), 32'd1);
        if (q3.size() != 0) chk("rnd_w1", 32'({ovf3, z3}), q3.pop_front());
        n3++;
      end
      if (rv && ir2) q2.push_back(ref_fn(17, 0, ra, rm));
      if (rv && ir3) q3.push_back(ref_fn(1, 1, ra, rm));
    end
  end

  // Hand-computed vectors: a, mode, ovf, z (SAT=0), z (SAT=1).
  localparam int NT = 12;
  logic [7:0] ta   [NT] = '{8'h05, 8'h05, 8'h05, 8'h05, 8'h80, 8'h80, 8'h80, 8'h00, 8'hFB, 8'h7F, 8'h80, 8'h00};
  logic [1:0] tm   [NT] = '{2'd0,  2'd1,  2'd2,  2'd3,  2'd1,  2'd3,  2'd2,  2'd3,  2'd2,  2'd1,  2'd0,  2'd1};
  logic       tovf [NT] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0};
  logic [7:0] tz0  [NT] = '{8'h05, 8'hFB, 8'h05, 8'hFB, 8'h80, 8'h80, 8'h80, 8'h00, 8'h05, 8'h81, 8'h80, 8'h00};
  logic [7:0] tz1  [NT] = '{8'h05, 8'hFB, 8'h05, 8'hFB, 8'h7F, 8'h80, 8'h7F, 8'h00, 8'h05, 8'h81, 8'h80, 8'h00};

  // Backpressure stream.
  logic [7:0] b_a [8] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
  logic [1:0] b_m [8] = '{2'd1,  2'd2,  2'd3,  2'd0,  2'd1,  2'd2,  2'd3,  2'd0};
  logic [7:0] b_z [8] = '{8'hEF, 8'h12, 8'hED, 8'h14, 8'hEB, 8'h16, 8'hE9, 8'h18};

  int         in_idx, out_idx, occ;
  logic       ordy, acc, emit, stalled;
  logic [9:0] held;
  logic [7:0] e8;

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; a = 8'h55; mode = 2'b01; out_ready = 1'b1;
    rv = 1'b0; ra = '0; rm = 2'b00; rr = 1'b1;

    // 1: reset with in_valid high
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_sat0", 32'({out_valid0, ovf0, z0}), 32'd0);
    chk("rst_out_sat1", 32'({out_valid1, ovf1, z1}), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    chk("rst_in_ready", 32'({in_ready0, in_ready1}), 32'd3);
    @(negedge clk);
    chk("rst_no_stale", 32'(out_valid0), 32'd0);

    // 2/3: mode sweep and overflow, back-to-back, 2-cycle latency
    for (int i = 0; i < NT + 2; i++) begin
      if (i < NT) drive(1'b1, ta[i], tm[i], 1'b1);
      else        drive(1'b0, 8'h00, 2'b00, 1'b1);
      if (i < NT) chk("tbl_in_ready", 32'({in_ready0, in_ready1}), 32'd3);
      if (i >= 2) begin
        chk("tbl_sat0", 32'({out_valid0, ovf0, z0}), 32'({1'b1, tovf[i-2], tz0[i-2]}));
        chk("tbl_sat1", 32'({out_valid1, ovf1, z1}), 32'({1'b1, tovf[i-2], tz1[i-2]}));
      end else begin
        chk("tbl_latency", 32'(out_valid0), 32'd0);
      end
    end
    drive(1'b0, 8'h00, 2'b00, 1'b1);
    chk("tbl_drained", 32'(out_valid0), 32'd0);

    // 4: backpressure, out_ready low for 3 cycles mid-stream
    in_idx = 0; out_idx = 0; occ = 0; stalled = 1'b0; held = '0;
    for (int c = 0; c < 40 && out_idx < 8; c++) begin
      ordy = !(c >= 3 && c <= 5);
      if (in_idx < 8) drive(1'b1, b_a[in_idx], b_m[in_idx], ordy);
      else            drive(1'b0, 8'h00, 2'b00, ordy);
      chk("bp_in_ready", 32'(in_ready0), 32'(ordy || occ < 2));
      if (stalled) chk("bp_stable", 32'({out_valid0, ovf0, z0}), 32'(held));
      stalled = out_valid0 && !ordy;
      held    = {1'b0, out_valid0, ovf0, z0};
      acc     = in_valid && in_ready0;
      emit    = out_valid0 && ordy;
      if (emit) begin
        chk("bp_data", 32'({ovf0, z0}), 32'({1'b0, b_z[out_idx]}));
        out_idx++;
      end
      if (acc) in_idx++;
      occ = occ + int'(acc) - int'(emit);
    end
    chk("bp_count", 32'(out_idx), 32'd8);

    // 5: full pipe with simultaneous accept/emit, then reset mid-burst
    drive(1'b1, 8'h20, 2'b01, 1'b0);
    drive(1'b1, 8'h21, 2'b01, 1'b0);
    chk("fill_in_ready", 32'(in_ready0), 32'd1);
    for (int k = 0; k < 10; k++) begin
      e8 = 8'h00 - (8'h20 + 8'(k));
      drive(1'b1, 8'h22 + 8'(k), 2'b01, 1'b1);
      chk("full_io", 32'({in_ready0, out_valid0, ovf0, z0}), 32'({2'b11, 1'b0, e8}));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", 32'({out_valid0, ovf0, z0}), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 8'h00, 2'b00, 1'b1);
      chk("mid_rst_no_stale", 32'(out_valid0), 32'd0);
    end

    // 6: random traffic on WIDTH=17/STAGES=4 and WIDTH=1/STAGES=1
    for (int c = 0; c < 800; c++) begin
      @(posedge clk);
      #1;
      rv = ($urandom_range(0, 3) != 0);
      ra = 17'($urandom);
      rm = 2'($urandom);
      rr = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #1;
    rv = 1'b0;
    rr = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("rnd_w17_drained", 32'(q2.size()), 32'd0);
    chk("rnd_w1_drained", 32'(q3.size()), 32'd0);
    chk("rnd_w17_traffic", 32'(n2 > 100), 32'd1);
    chk("rnd_w1_traffic", 32'(n3 > 100), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
